// File: rtl/seq_alu.sv
// seq_alu: multi-cycle execute-stage ALU for RV32I.
//   Non-shift ops complete one cycle after accept; shifts run through an
//   iterative one-bit-per-cycle shifter, so a shift by N takes N+1 cycles.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           synchronous abort back to IDLE, drops any held result
//   in_valid/ready  request handshake carrying alufn, a, b
//   out_valid/ready response handshake carrying result and flags
//   result          registered result; zf/sf derived from it
//   cf, vf          carry / signed overflow of ADD and SUB, else 0
module seq_alu #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alufn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zf,
  output logic            sf,
  output logic            cf,
  output logic            vf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_n;
  logic              accept, is_shift, last_step;
  logic [SHW-1:0]    shamt, cnt;
  logic [XLEN-1:0]   acc, acc_sh;
  logic              sh_left, sh_arith;

  // single-cycle datapath
  logic              sub;
  logic [XLEN-1:0]   addend, alu_res;
  logic [XLEN:0]     sum;
  logic              alu_cf, alu_vf;

  always_comb begin
    sub     = (alufn == 4'b0001);
    addend  = sub ? ~b : b;
    sum     = {1'b0, a} + {1'b0, addend} + {{XLEN{1'b0}}, sub};
    alu_res = '0;
    alu_cf  = 1'b0;
    alu_vf  = 1'b0;
    case (alufn)
      4'b0000, 4'b0001: begin
        alu_res = sum[XLEN-1:0];
        alu_cf  = sum[XLEN];
        // overflow: both addends share a sign that the sum does not
        alu_vf  = (a[XLEN-1] == addend[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
      4'b0011: alu_res = b;
      4'b0100: alu_res = a | b;
      4'b0101: alu_res = a & b;
      4'b0111: alu_res = a ^ b;
      4'b1101: alu_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1111: alu_res = {{(XLEN-1){1'b0}}, (a < b)};
      default: alu_res = '0;
    endcase
  end

  assign is_shift  = (alufn == 4'b1000) || (alufn == 4'b1001) || (alufn == 4'b1010);
  assign shamt     = b[SHW-1:0];
  assign last_step = (cnt == SHW'(1));
  assign acc_sh    = sh_left ? {acc[XLEN-2:0], 1'b0}
                             : {sh_arith & acc[XLEN-1], acc[XLEN-1:1]};

  // handshake + next state
  always_comb begin
    in_ready = !rst && (state == IDLE || (state == DONE && out_ready));
    accept   = in_valid && in_ready && !flush;
    state_n  = state;
    case (state)
      IDLE, DONE: begin
        if (accept)
          state_n = (is_shift && shamt != '0) ? SHIFT : DONE;
        else if (state == DONE && out_ready)
          state_n = IDLE;
      end
      SHIFT:   if (last_step) state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // operands are captured only on accept; result only changes on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      cnt      <= '0;
      sh_left  <= 1'b0;
      sh_arith <= 1'b0;
      result   <= '0;
      cf       <= 1'b0;
      vf       <= 1'b0;
    end else if (accept) begin
      acc      <= a;
      cnt      <= shamt;
      sh_left  <= (alufn[1:0] == 2'b00);
      sh_arith <= alufn[1];
      if (!is_shift) begin
        result <= alu_res;
        cf     <= alu_cf;
        vf     <= alu_vf;
      end else if (shamt == '0) begin
        result <= a;
        cf     <= 1'b0;
        vf     <= 1'b0;
      end
    end else if (state == SHIFT && !flush) begin
      acc <= acc_sh;
      cnt <= cnt - SHW'(1);
      if (last_step) begin
        result <= acc_sh;
        cf     <= 1'b0;
        vf     <= 1'b0;
      end
    end
  end

  assign out_valid = (state == DONE);
  assign zf        = (result == '0);
  assign sf        = result[XLEN-1];

endmodule

// File: tb/tb_seq_alu.sv
// Randomized + directed bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic        zf, sf, cf, vf;
  logic [3:0]  alufn;
  logic [31:0] a, b, result;
  int          nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  seq_alu #(.XLEN(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alufn(alufn), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zf(zf), .sf(sf), .cf(cf), .vf(vf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] fn, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic c, output logic v,
                                output int lat);
    longint sx, sy, ux, uy, t;
    int sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    sh = int'(y[4:0]);
    r = 32'h0; c = 1'b0; v = 1'b0; lat = 1; t = 0;
    case (fn)
      4'd0:  begin r = x + y; c = ((ux + uy) >> 32) != 0; t = sx + sy;
                   v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'd1:  begin r = x - y; c = (x >= y); t = sx - sy;
                   v = (t > 64'sd2147483647) || (t < -64'sd2147483648); end
      4'd3:  r = y;
      4'd4:  r = x | y;
      4'd5:  r = x & y;
      4'd7:  r = x ^ y;
      4'd13: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd15: r = (x < y) ? 32'd1 : 32'd0;
      4'd8:  begin r = x << sh; lat = 1 + sh; end
      4'd9:  begin r = x >> sh; lat = 1 + sh; end
      4'd10: begin r = $signed(x) >>> sh; lat = 1 + sh; end
      default: r = 32'h0;
    endcase
  endfunction

  // issue one op from IDLE, check latency/result/flags, hold back-pressure, retire
  task automatic do_op(input logic [3:0] fn, input logic [31:0] x, input logic [31:0] y,
                       input int hold);
    logic [31:0] er;
    logic ec, ev;
    int el, lat;
    model(fn, x, y, er, ec, ev, el);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; alufn = fn; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; alufn = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(el));
    chk("result", result, er);
    chk("zf", 32'(zf), 32'(er == 32'h0));
    chk("sf", 32'(sf), 32'(er[31]));
    chk("cf", 32'(cf), 32'(ec));
    chk("vf", 32'(vf), 32'(ev));
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_result", result, er);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("retired", 32'(out_valid), 32'd0);
  endtask

  logic [3:0]  fns [16];
  logic [31:0] r1, r2, r3;
  logic        dc, dv;
  int          dl;
  bit          seen;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alufn = 4'h0; a = 32'h0; b = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {28'h0, zf, sf, cf, vf}, 32'h8);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0; #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // directed corner cases
    do_op(4'd0,  32'h7FFFFFFF, 32'h1, 0);
    do_op(4'd1,  32'd5, 32'd5, 0);
    do_op(4'd13, 32'hFFFFFFFF, 32'd1, 0);
    do_op(4'd15, 32'hFFFFFFFF, 32'd1, 0);
    do_op(4'd10, 32'h80000000, 32'd31, 0);
    do_op(4'd9,  32'h80000000, 32'd31, 0);
    do_op(4'd8,  32'hDEADBEEF, 32'd0, 0);
    do_op(4'd6,  32'h12345678, 32'h9ABCDEF0, 0);

    // back-to-back with out_ready high, then back-pressure
    out_ready = 1'b1;
    model(4'd0, 32'h11111111, 32'h22222222, r1, dc, dv, dl);
    model(4'd7, 32'hF0F0F0F0, 32'h0FF00FF0, r2, dc, dv, dl);
    model(4'd4, 32'h00000F00, 32'h000000F0, r3, dc, dv, dl);
    in_valid = 1'b1; alufn = 4'd0; a = 32'h11111111; b = 32'h22222222;
    @(posedge clk); #1;
    chk("b2b1_valid", 32'(out_valid), 32'd1);
    chk("b2b1_result", result, r1);
    chk("b2b1_in_ready", 32'(in_ready), 32'd1);
    alufn = 4'd7; a = 32'hF0F0F0F0; b = 32'h0FF00FF0;
    @(posedge clk); #1;
    chk("b2b2_valid", 32'(out_valid), 32'd1);
    chk("b2b2_result", result, r2);
    alufn = 4'd4; a = 32'h00000F00; b = 32'h000000F0;
    @(posedge clk); #1;
    chk("b2b3_valid", 32'(out_valid), 32'd1);
    chk("b2b3_result", result, r3);
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("bp_result", result, r3);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_retired", 32'(out_valid), 32'd0);

    // flush mid-shift
    in_valid = 1'b1; alufn = 4'd8; a = 32'h1; b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 32'(seen), 32'd0);
    do_op(4'd3, 32'hCAFEF00D, 32'h12345000, 1);

    // reset mid-shift
    in_valid = 1'b1; alufn = 4'd10; a = 32'h80000000; b = 32'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_flags", {28'h0, zf, sf, cf, vf}, 32'h8);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0; #1;
    chk("mid_rst_ready_after", 32'(in_ready), 32'd1);
    do_op(4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);

    // random ops over all codes
    for (int i = 0; i < 16; i++) fns[i] = 4'(i);
    for (int i = 0; i < 150; i++) begin
      do_op(fns[$urandom_range(0, 15)], $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
